regfile_psr: RTL and testbench
==============================

Name: regfile_psr

Overview:
- Operand-supply and write-back stage for the 16-bit ALU datapath.
- Holds a 16x16 general register file and the 5-bit processor status register (PSR).
- Produces the ALU A/B operands (B may be a sign- or zero-extended 8-bit immediate) and the ALU carry-in.
- Captures the ALU result and flags on the following clock edge.

Parameters:
- DATA_W, 16, register and operand width.
- NREGS, 16, number of general registers.
- ADDR_W, 4, register index width (log2 NREGS).
- FLAG_W, 5, PSR width; bit order {Z, C, F(overflow), L, N} = [4:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rsrc_addr  in  ADDR_W  source register index; drives op_a.
- rdst_addr  in  ADDR_W  destination register index; drives op_b in register mode and is the write index.
- imm  in  8  instruction immediate.
- imm_sel  in  1  1: op_b = extended imm; 0: op_b = R[rdst_addr].
- imm_signed  in  1  1: sign-extend imm; 0: zero-extend.
- op_a  out  DATA_W  ALU operand A (combinational read).
- op_b  out  DATA_W  ALU operand B (combinational read or immediate).
- cin  out  1  PSR carry bit (PSR[3]) to the ALU.
- wb_data  in  DATA_W  ALU result C.
- wb_en  in  1  write wb_data into R[rdst_addr] at the next rising edge.
- alu_flags  in  FLAG_W  ALU Flags output.
- flags_we  in  FLAG_W  per-bit PSR update mask.
- psr  out  FLAG_W  current PSR contents.

Behaviour:
- Reset:
  - Asserting reset immediately clears all registers and the PSR to 0, with no clock edge required.
  - Because op_a, op_b and cin are read combinationally from that state, they read 0 during reset, except op_b when imm_sel=1, which shows the extended immediate.
  - Writes are ignored while reset is high.
  - Deassertion is synchronised externally.
- Reads:
  - Purely combinational; zero-cycle latency from an address change to op_a/op_b.
  - rsrc_addr == rdst_addr is legal; both ports return the same register.
- Immediate extension:
  - imm_signed=1: op_b = {{8{imm[7]}}, imm}.
  - imm_signed=0: op_b = {8'h00, imm}.
  - When imm_sel=0, imm and imm_signed are ignored.
- Write:
  - On a rising clk with wb_en=1, R[rdst_addr] <= wb_data.
  - Without the optional feature, the new value is visible on reads only after the edge (read-old during the write cycle).
- PSR update:
  - On each rising clk, for each bit i: PSR[i] <= flags_we[i] ? alu_flags[i] : PSR[i].
  - Independent of wb_en. This allows CMP, which sets flags with no write-back, and ADDU, which writes back with no flag update.
- Carry: cin = PSR[3] combinationally, so ADDC/SUBC consume the carry produced by the previous flag-setting instruction.
- Simultaneous events:
  - A write and a PSR update in the same cycle both take effect.
  - Write-back and read of the same register in the same cycle follow the read rule above, or the forwarding rule under the optional feature.
- Out-of-range addresses cannot occur (NREGS = 2^ADDR_W); no wrap handling is needed.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding: if wb_en=1 and a read address equals rdst_addr, that port returns wb_data in the same cycle.
  - cin forwards alu_flags[3] when flags_we[3]=1.
  - The immediate path is unaffected.
- Undefined: reads always return stored state (read-old), as described in Behaviour.

Decomposition:
- Shared package/include holds:
  - DATA_W, ADDR_W, FLAG_W.
  - Flag bit index constants FLAG_Z=4, FLAG_C=3, FLAG_F=2, FLAG_L=1, FLAG_N=0.
  - The 4-bit ALU opcode constants, so decoder, ALU and this block agree.
- One natural sub-module, psr_reg: the masked 5-bit flag register with async reset, instantiated once.
- The register array and immediate mux stay in regfile_psr.

Test Plan:
- Reset clear: write 16'hBEEF to R5; assert reset mid-cycle with no clock edge -> R5 reads 16'h0000, psr=5'b00000 and cin=0 immediately.
- Write/read: wb_en=1, rdst_addr=3, wb_data=16'h1234, clock -> rsrc_addr=3 gives op_a=16'h1234. Without the macro, op_a shows the old value 16'h0000 during the write cycle.
- Immediate: imm=8'hF0, imm_sel=1.
  - imm_signed=1 -> op_b=16'hFFF0.
  - imm_signed=0 -> op_b=16'h00F0.
- Masked flags: psr=0.
  - alu_flags=5'b11111, flags_we=5'b01100, clock -> psr=5'b01100 and cin=1.
  - Then flags_we=0 with alu_flags=0, clock -> psr unchanged.
- Same-address ports: R7=16'hA5A5; rsrc_addr=rdst_addr=7, imm_sel=0 -> op_a=op_b=16'hA5A5.
- Bypass (REGFILE_BYPASS_EN): wb_en=1, rdst_addr=rsrc_addr=2, wb_data=16'h00FF -> op_a=16'h00FF before the edge. With flags_we[3]=1 and alu_flags[3]=1, cin=1 before the edge.

Source files
------------

// File: rtl/regfile_psr_pkg.sv
// Shared widths, PSR flag bit positions and ALU opcodes for the 16-bit datapath.
package regfile_psr_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned FLAG_W = 5;

    // PSR bit order {Z, C, F, L, N}
    localparam int unsigned FLAG_Z = 4;
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_ADDU = 4'h1,
        ALU_ADDC = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_SUBC = 4'h4,
        ALU_CMP  = 4'h5,
        ALU_AND  = 4'h6,
        ALU_OR   = 4'h7,
        ALU_XOR  = 4'h8,
        ALU_NOT  = 4'h9,
        ALU_LSH  = 4'hA,
        ALU_RSH  = 4'hB,
        ALU_ASH  = 4'hC,
        ALU_MOV  = 4'hD,
        ALU_LUI  = 4'hE,
        ALU_NOP  = 4'hF
    } alu_op_e;

endpackage

// File: rtl/regfile_psr_psr_reg.sv
// Processor status register: per-bit write-masked flag storage with async clear.
module psr_reg
    import regfile_psr_pkg::*;
#(
    parameter int unsigned WIDTH = FLAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] flags,
    input  logic [WIDTH-1:0] we,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= (q & ~we) | (flags & we);
        end
    end

endmodule

// File: rtl/regfile_psr.sv
// Register file, immediate operand mux and PSR for the 16-bit ALU datapath.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding.
module regfile_psr
    import regfile_psr_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_psr_pkg::DATA_W,
    parameter int unsigned NREGS  = regfile_psr_pkg::NREGS,
    parameter int unsigned ADDR_W = regfile_psr_pkg::ADDR_W,
    parameter int unsigned FLAG_W = regfile_psr_pkg::FLAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rsrc_addr,
    input  logic [ADDR_W-1:0] rdst_addr,
    input  logic [7:0]        imm,
    input  logic              imm_sel,
    input  logic              imm_signed,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              cin,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_en,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [FLAG_W-1:0] flags_we,
    output logic [FLAG_W-1:0] psr
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] imm_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[rdst_addr] <= wb_data;
        end
    end

    psr_reg #(
        .WIDTH (FLAG_W)
    ) u_psr (
        .clk   (clk),
        .reset (reset),
        .flags (alu_flags),
        .we    (flags_we),
        .q     (psr)
    );

    always_comb begin
        rd_a = regs[rsrc_addr];
        rd_b = regs[rdst_addr];
        cin  = psr[FLAG_C];
`ifdef REGFILE_BYPASS_EN
        // rdst_addr is the write index, so a register-mode op_b always hits when wb_en is set
        if (wb_en && (rsrc_addr == rdst_addr)) begin
            rd_a = wb_data;
        end
        if (wb_en) begin
            rd_b = wb_data;
        end
        if (flags_we[FLAG_C]) begin
            cin = alu_flags[FLAG_C];
        end
`endif
    end

    always_comb begin
        if (imm_signed) begin
            imm_ext = {{(DATA_W-8){imm[7]}}, imm};
        end else begin
            imm_ext = {{(DATA_W-8){1'b0}}, imm};
        end
    end

    assign op_a = rd_a;
    assign op_b = imm_sel ? imm_ext : rd_b;

endmodule

// File: tb/tb_regfile_psr.sv
// Directed table-driven bench for regfile_psr, plus reset and bypass sequences.
module tb_regfile_psr;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rsrc_addr;
    logic [3:0]  rdst_addr;
    logic [7:0]  imm;
    logic        imm_sel;
    logic        imm_signed;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic [15:0] wb_data;
    logic        wb_en;
    logic [4:0]  alu_flags;
    logic [4:0]  flags_we;
    logic [4:0]  psr;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_psr dut (
        .clk        (clk),
        .reset      (reset),
        .rsrc_addr  (rsrc_addr),
        .rdst_addr  (rdst_addr),
        .imm        (imm),
        .imm_sel    (imm_sel),
        .imm_signed (imm_signed),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .wb_data    (wb_data),
        .wb_en      (wb_en),
        .alu_flags  (alu_flags),
        .flags_we   (flags_we),
        .psr        (psr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rsrc;
        logic [3:0]  rdst;
        logic [7:0]  imm;
        logic        isel;
        logic        isgn;
        logic        wen;
        logic [15:0] wdata;
        logic [4:0]  fl;
        logic [4:0]  we;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ec;
        logic [4:0]  ep;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rsrc_addr  = v.rsrc;
        rdst_addr  = v.rdst;
        imm        = v.imm;
        imm_sel    = v.isel;
        imm_signed = v.isgn;
        wb_en      = v.wen;
        wb_data    = v.wdata;
        alu_flags  = v.fl;
        flags_we   = v.we;
    endtask

    initial begin
        logic [15:0] ea;
        logic [15:0] eb;
        logic        ec;

        // Expected values assume stored-state (read-old) reads; bypass adjustments applied in the loop.
        //           rsrc   rdst   imm    isel  isgn  wen   wdata     fl        we        ea        eb        ec    ep
        vecs[0]  = '{4'd3,  4'd3,  8'h00, 1'b0, 1'b0, 1'b1, 16'h1234, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 1'b0, 5'b00000};
        vecs[1]  = '{4'd3,  4'd5,  8'hF0, 1'b1, 1'b1, 1'b0, 16'h0000, 5'b00000, 5'b00000, 16'h1234, 16'hFFF0, 1'b0, 5'b00000};
        vecs[2]  = '{4'd3,  4'd5,  8'hF0, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00000, 5'b00000, 16'h1234, 16'h00F0, 1'b0, 5'b00000};
        vecs[3]  = '{4'd0,  4'd7,  8'h00, 1'b0, 1'b0, 1'b1, 16'hA5A5, 5'b11111, 5'b01100, 16'h0000, 16'h0000, 1'b0, 5'b00000};
        vecs[4]  = '{4'd7,  4'd7,  8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 5'b00000, 16'hA5A5, 16'hA5A5, 1'b1, 5'b01100};
        vecs[5]  = '{4'd3,  4'd7,  8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 5'b00000, 16'h1234, 16'hA5A5, 1'b1, 5'b01100};
        vecs[6]  = '{4'd3,  4'd3,  8'h7F, 1'b1, 1'b1, 1'b0, 16'h0000, 5'b10001, 5'b11011, 16'h1234, 16'h007F, 1'b1, 5'b01100};
        vecs[7]  = '{4'd9,  4'd9,  8'h00, 1'b0, 1'b0, 1'b1, 16'hFFFF, 5'b11111, 5'b00000, 16'h0000, 16'h0000, 1'b0, 5'b10101};
        vecs[8]  = '{4'd9,  4'd15, 8'h80, 1'b1, 1'b1, 1'b1, 16'h8001, 5'b00000, 5'b00001, 16'hFFFF, 16'hFF80, 1'b0, 5'b10101};
        vecs[9]  = '{4'd15, 4'd0,  8'h80, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 5'b00000, 16'h8001, 16'h0000, 1'b0, 5'b10100};
        vecs[10] = '{4'd15, 4'd15, 8'h80, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b00000, 5'b00000, 16'h8001, 16'h0080, 1'b0, 5'b10100};

        // Reset state; immediate path still live during reset
        reset = 1'b1;
        drive('{4'd4, 4'd6, 8'h80, 1'b1, 1'b1, 1'b0, 16'h0000, 5'b00000, 5'b00000, 16'h0, 16'h0, 1'b0, 5'b0});
        #1;
        check("reset_op_a", op_a, 16'h0000);
        check("reset_op_b_imm", op_b, 16'hFF80);
        check("reset_cin", 16'(cin), 16'h0000);
        check("reset_psr", 16'(psr), 16'h0000);
        imm_sel = 1'b0;
        #1;
        check("reset_op_b_reg", op_b, 16'h0000);

        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            ea = vecs[i].ea;
            eb = vecs[i].eb;
            ec = vecs[i].ec;
`ifdef REGFILE_BYPASS_EN
            if (vecs[i].wen && (vecs[i].rsrc == vecs[i].rdst)) ea = vecs[i].wdata;
            if (vecs[i].wen && !vecs[i].isel) eb = vecs[i].wdata;
            if (vecs[i].we[3]) ec = vecs[i].fl[3];
`endif
            check($sformatf("v%0d_op_a", i), op_a, ea);
            check($sformatf("v%0d_op_b", i), op_b, eb);
            check($sformatf("v%0d_cin", i), 16'(cin), 16'(ec));
            check($sformatf("v%0d_psr", i), 16'(psr), 16'(vecs[i].ep));
        end

        // Mid-cycle asynchronous reset after writing R5 and setting flags
        @(negedge clk);
        drive('{4'd0, 4'd5, 8'h00, 1'b0, 1'b0, 1'b1, 16'hBEEF, 5'b11111, 5'b11111, 16'h0, 16'h0, 1'b0, 5'b0});
        @(negedge clk);
        drive('{4'd5, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b00000, 5'b00000, 16'h0, 16'h0, 1'b0, 5'b0});
        #1;
        check("pre_reset_r5", op_a, 16'hBEEF);
        check("pre_reset_psr", 16'(psr), 16'h001F);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_r5", op_a, 16'h0000);
        check("async_reset_r15", 16'(dut.regs[15]), 16'h0000);
        check("async_reset_psr", 16'(psr), 16'h0000);
        check("async_reset_cin", 16'(cin), 16'h0000);

        // Writes and flag updates are ignored while reset is held
        @(negedge clk);
        drive('{4'd6, 4'd6, 8'h00, 1'b0, 1'b0, 1'b1, 16'h1111, 5'b11111, 5'b11111, 16'h0, 16'h0, 1'b0, 5'b0});
        @(negedge clk);
        wb_en    = 1'b0;
        flags_we = 5'b00000;
        #1;
        check("reset_hold_write", op_a, 16'h0000);
        check("reset_hold_psr", 16'(psr), 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Write-cycle read and post-edge read of the same register
        @(negedge clk);
        drive('{4'd2, 4'd2, 8'h00, 1'b0, 1'b0, 1'b1, 16'h00FF, 5'b01000, 5'b01000, 16'h0, 16'h0, 1'b0, 5'b0});
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_op_a", op_a, 16'h00FF);
        check("bypass_cin", 16'(cin), 16'h0001);
`else
        check("read_old_op_a", op_a, 16'h0000);
        check("read_old_cin", 16'(cin), 16'h0000);
`endif
        @(negedge clk);
        wb_en    = 1'b0;
        flags_we = 5'b00000;
        alu_flags = 5'b00000;
        #1;
        check("post_write_op_a", op_a, 16'h00FF);
        check("post_write_cin", 16'(cin), 16'h0001);
        check("post_write_psr", 16'(psr), 16'h0008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
